// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler
// Drains N per-port input FIFOs onto one shared valid/ready output link.
// Grants rotate round-robin; a granted FIFO may be read up to BURST times
// in a row before the grant is handed on. A 2-entry output buffer plus a
// credit check on (occupancy + in-flight reads) keeps one word per cycle
// flowing without ever overflowing the buffer when the consumer stalls.

module fifo_rr_scheduler #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         fifo_empty,
    input  logic [N*WIDTH-1:0]   fifo_dout,
    output logic [N-1:0]         fifo_rd_en,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         grant
);

    localparam int SW  = $clog2(N);
    localparam int SW1 = SW + 1;
    localparam int CW  = $clog2(BURST + 1);

    localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);
    localparam logic [N-1:0]  ONE_HOT0   = N'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    // Scheduler state
    logic [0:0]    r_state;
    logic [N-1:0]  r_grant;
    logic [SW-1:0] r_gidx;
    logic [SW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;

    // Read issued last cycle; its data is on fifo_dout this cycle
    logic          r_inflight;
    logic [SW-1:0] r_if_src;

    // Output buffer: entry 0 is the head presented on the link
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_e0_data;
    logic [SW-1:0]    r_e0_src;
    logic [WIDTH-1:0] r_e1_data;
    logic [SW-1:0]    r_e1_src;

    // Combinational helpers
    logic             w_pop;
    logic [2:0]       w_level;
    logic             w_credit;
    logic             w_rd;
    logic             w_found;
    logic [SW-1:0]    w_pick;
    logic [WIDTH-1:0] w_dout [N];
    logic [WIDTH-1:0] w_cap;

    // Index of the FIFO after idx, wrapping modulo N
    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] idx);
        logic [SW-1:0] v_next;
        if (idx == SW'(N - 1)) begin
            v_next = '0;
        end else begin
            v_next = idx + SW'(1);
        end
        return v_next;
    endfunction

    assign w_pop   = (r_occ != 2'd0) && out_ready;
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};

    // Credit: a read may issue only if the buffer can still absorb its word
    always_comb begin
        w_credit = ((w_level - {2'b00, w_pop}) < 3'd2);
    end

    // Read strobe: granted FIFO non-empty, credit available, not in reset
    always_comb begin
        w_rd = reset && (r_state == ST_SERVE) && !fifo_empty[r_gidx] && w_credit;
    end

    // Drive exactly the granted FIFO's read strobe when a read issues
    always_comb begin
        fifo_rd_en = '0;
        if (w_rd) begin
            fifo_rd_en[r_gidx] = 1'b1;
        end else begin
            fifo_rd_en = '0;
        end
    end

    // Unpack per-FIFO data words and select the one read last cycle
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_dout[i] = fifo_dout[i*WIDTH +: WIDTH];
        end
        w_cap = w_dout[r_if_src];
    end

    // Round-robin scan: first non-empty FIFO starting at the pointer
    always_comb begin : scan_blk
        logic [SW1-1:0] v_sum;
        logic [SW1-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_sum   = '0;
        v_idx   = '0;
        for (int k = 0; k < N; k++) begin
            v_sum = {1'b0, r_ptr} + SW1'(k);
            v_idx = (v_sum >= SW1'(N)) ? (v_sum - SW1'(N)) : v_sum;
            if (!w_found && !fifo_empty[v_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v_idx[SW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant FSM: pick in IDLE, read up to BURST words in SERVE, then hand on
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_if_src   <= '0;
        end else begin
            r_inflight <= w_rd;
            r_if_src   <= r_gidx;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= ONE_HOT0 << w_pick;
                        r_gidx  <= w_pick;
                        r_cnt   <= '0;
                        r_state <= ST_SERVE;
                    end else begin
                        r_grant <= '0;
                    end
                end
                ST_SERVE: begin
                    if (w_rd) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == BURST_LAST) begin
                            // Burst complete: release on this edge
                            r_ptr   <= next_idx(r_gidx);
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else if (fifo_empty[r_gidx]) begin
                        // Granted FIFO ran dry: release early
                        r_ptr   <= next_idx(r_gidx);
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                    // Otherwise a credit stall: hold grant and count
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Output buffer: capture read data, pop on handshake, shift toward head
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_occ     <= 2'd0;
            r_e0_data <= '0;
            r_e0_src  <= '0;
            r_e1_data <= '0;
            r_e1_src  <= '0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (r_inflight) begin
                        r_e0_data <= w_cap;
                        r_e0_src  <= r_if_src;
                        r_occ     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_pop) begin
                        r_e0_data <= w_cap;
                        r_e0_src  <= r_if_src;
                    end else if (r_inflight) begin
                        r_e1_data <= w_cap;
                        r_e1_src  <= r_if_src;
                        r_occ     <= 2'd2;
                    end else if (w_pop) begin
                        r_occ <= 2'd0;
                    end
                end
                2'd2: begin
                    // Credit rule guarantees no push without a pop when full
                    if (w_pop) begin
                        r_e0_data <= r_e1_data;
                        r_e0_src  <= r_e1_src;
                        if (r_inflight) begin
                            r_e1_data <= w_cap;
                            r_e1_src  <= r_if_src;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_occ <= 2'd0;
                end
            endcase
        end
    end

    assign out_data  = r_e0_data;
    assign out_src   = r_e0_src;
    assign out_valid = (r_occ != 2'd0);
    assign grant     = r_grant;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Self-checking bench for fifo_rr_scheduler: behavioural sync FIFOs feed the
// block, a scoreboard queue holds the expected {src,data} output order.
`timescale 1ns/1ps
module tb_fifo_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 4;

    logic           clk        = 1'b0;
    logic           reset      = 1'b0;
    logic [N-1:0]   fifo_empty = '1;
    logic [N*W-1:0] fifo_dout  = '0;
    logic [N-1:0]   fifo_rd_en;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready  = 1'b1;
    logic [N-1:0]   grant;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mem [N][64];
    int head [N] = '{default: 0};
    int tail [N] = '{default: 0};
    logic [9:0] exp_q [$];

    fifo_rr_scheduler #(.N(N), .WIDTH(W), .BURST(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant      (grant)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    // Word value: FIFO index in the top bits, sequence number below
    function automatic logic [7:0] wv(input int i, input int idx);
        logic [31:0] a;
        logic [31:0] b;
        a = i;
        b = idx;
        return {a[1:0], b[5:0]};
    endfunction

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            mem[i][tail[i]] = wv(i, tail[i]);
            tail[i]++;
        end
    endtask

    task automatic expect_word(input int i, input int idx);
        logic [31:0] a;
        a = i;
        exp_q.push_back({a[1:0], wv(i, idx)});
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && grant == '0 && !out_valid && fifo_rd_en == '0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'b0, done}, 32'd1);
        chk({tag, "_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Sync FIFO model: 1-cycle read latency, empty updates at the read edge
    always @(posedge clk) begin : fifo_model
        int h;
        for (int i = 0; i < N; i++) begin
            h = head[i];
            if (fifo_rd_en[i] && (h < tail[i])) begin
                fifo_dout[i*W +: W] <= mem[i][h];
                h = h + 1;
                head[i] = h;
            end
            fifo_empty[i] <= !(h < tail[i]);
        end
    end

    // Monitor: protocol checks and scoreboard comparison on each handshake
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (reset) begin
            chk("rd_onehot", {31'b0, ($countones(fifo_rd_en) <= 1)}, 32'd1);
            chk("rd_on_empty", {28'b0, fifo_rd_en & fifo_empty}, 32'd0);
            chk("grant_onehot", {31'b0, ($countones(grant) <= 1)}, 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra", {22'b0, out_src, out_data}, 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_word", {22'b0, out_src, out_data}, {22'b0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int t;
        int base [N];
        logic [13:0] pat;
        int first;
        int last;
        int npop;
        logic [7:0] held;

        // 1: reset held with data present, then first grant to FIFO 0
        for (int i = 0; i < N; i++) begin
            base[i] = tail[i];
            load(i, 2);
        end
        for (int i = 0; i < N; i++) begin
            expect_word(i, base[i]);
            expect_word(i, base[i] + 1);
        end
        repeat (3) begin
            @(negedge clk);
            chk("t1_rd_en_rst", {28'b0, fifo_rd_en}, 32'd0);
            chk("t1_valid_rst", {31'b0, out_valid}, 32'd0);
            chk("t1_grant_rst", {28'b0, grant}, 32'd0);
            chk("t1_data_rst", {24'b0, out_data}, 32'd0);
            chk("t1_src_rst", {30'b0, out_src}, 32'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("t1_first_grant", {28'b0, grant}, 32'b0001);
        wait_drain("t1_drain");

        // 2: single FIFO with 10 words -> bursts 4,4,2 with 1-cycle gaps
        reset_dut();
        base[2] = tail[2];
        load(2, 10);
        for (int k = 0; k < 10; k++) expect_word(2, base[2] + k);
        t = 0;
        @(negedge clk);
        while (!fifo_rd_en[2] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t2_start", {31'b0, (t < 20)}, 32'd1);
        pat = '0;
        for (int k = 0; k < 14; k++) begin
            pat = {pat[12:0], fifo_rd_en[2]};
            @(negedge clk);
        end
        chk("t2_burst_pattern", {18'b0, pat}, {18'b0, 14'b11110111101100});
        wait_drain("t2_drain");

        // 3: all FIFOs loaded -> fair rotation, 4 words per 5 cycles
        reset_dut();
        for (int i = 0; i < N; i++) begin
            base[i] = tail[i];
            load(i, 8);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < B; k++)
                    expect_word(i, base[i] + r*B + k);
        first = -1;
        last  = -1;
        npop  = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                npop++;
            end
        end
        chk("t3_word_count", npop, 32'd32);
        chk("t3_span", last - first + 1, 32'd39);
        wait_drain("t3_drain");

        // 4: consumer stall caps reads at buffer depth, then recovers
        reset_dut();
        out_ready = 1'b0;
        base[1] = tail[1];
        load(1, 6);
        for (int k = 0; k < 6; k++) expect_word(1, base[1] + k);
        repeat (8) @(negedge clk);
        held = out_data;
        chk("t4_valid", {31'b0, out_valid}, 32'd1);
        chk("t4_head", {24'b0, out_data}, {24'b0, wv(1, base[1])});
        chk("t4_src", {30'b0, out_src}, 32'd1);
        chk("t4_grant_held", {28'b0, grant}, 32'b0010);
        chk("t4_reads_so_far", head[1] - base[1], 32'd2);
        repeat (3) begin
            @(negedge clk);
            chk("t4_rd_stalled", {28'b0, fifo_rd_en}, 32'd0);
            chk("t4_data_stable", {24'b0, out_data}, {24'b0, held});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain("t4_drain");

        // 5: pointer at 3 -> FIFO 3 served, wrap, then FIFO 0
        reset_dut();
        base[2] = tail[2];
        load(2, 1);
        expect_word(2, base[2]);
        wait_drain("t5_prep_drain");
        base[3] = tail[3];
        base[0] = tail[0];
        load(3, 1);
        load(0, 1);
        expect_word(3, base[3]);
        expect_word(0, base[0]);
        wait_drain("t5_drain");

        // 6: reset the cycle after a read -> in-flight word discarded
        reset_dut();
        base[1] = tail[1];
        load(1, 3);
        t = 0;
        @(negedge clk);
        while (!fifo_rd_en[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t6_start", {31'b0, (t < 20)}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t6_rd_en_in_reset", {28'b0, fifo_rd_en}, 32'd0);
        @(posedge clk); #1;
        chk("t6_grant", {28'b0, grant}, 32'd0);
        chk("t6_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_data", {24'b0, out_data}, 32'd0);
        chk("t6_src", {30'b0, out_src}, 32'd0);
        chk("t6_rd_en", {28'b0, fifo_rd_en}, 32'd0);
        expect_word(1, base[1] + 1);
        expect_word(1, base[1] + 2);
        reset = 1'b1;
        wait_drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Drains N sync_fifo instances, one per mesh input port, onto a single shared output link with a valid/ready handshake.
- Grants are round-robin, with up to BURST consecutive reads per grant.
- The block owns every FIFO rd_en; the FIFO writers stay independent.
- Sits between the per-port input FIFOs and the router crossbar/link serializer in the mesh node.

Parameters:
- N, 4, number of FIFOs (requesters), N >= 2.
- WIDTH, 8, data word width; matches the sync_fifo width.
- BURST, 4, maximum consecutive reads from one FIFO per grant, >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- fifo_empty  in  N  empty flag of FIFO i.
- fifo_dout  in  N*WIDTH  packed dout of the FIFOs; FIFO i occupies bits [i*WIDTH +: WIDTH].
- fifo_rd_en  out  N  read strobe to FIFO i; at most one bit high in any cycle.
- out_data  out  WIDTH  head word of the output buffer.
- out_src  out  clog2(N)  index of the FIFO that out_data came from.
- out_valid  out  1  out_data/out_src valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- grant  out  N  one-hot current grant; all zero in IDLE.

Behaviour:
- Reset values: fifo_rd_en=0, grant=0, out_valid=0, out_data=0, out_src=0, rr pointer=0, burst count=0, buffer occupancy=0, in-flight=0, state=IDLE.
- FIFO read latency is 1 cycle. fifo_dout[i] is captured the cycle after fifo_rd_en[i] was high. fifo_empty updates at the same edge as the read.
- Output buffer: 2-entry FIFO of {data, src}. out_data, out_src and out_valid are driven from its head.
- A pop occurs when out_valid && out_ready.
- Credit rule: a read may issue in cycle t only if (occupancy + inflight − pop_t) < 2. This allows one word per cycle sustained and never overflows the buffer.
- A read never issues to a FIFO whose fifo_empty is high in that cycle.
- FSM states are IDLE and SERVE.
- IDLE:
  - Scan i = ptr, ptr+1, … mod N for the first FIFO with !fifo_empty[i].
  - If one is found: grant <= onehot(i), burst count <= 0, go to SERVE.
  - Granting takes one cycle; no read issues in the IDLE cycle.
- SERVE with grant g:
  - Each cycle where !fifo_empty[g] and the credit rule holds: assert fifo_rd_en[g] and increment the burst count.
  - Release the grant when the count reaches BURST, or when fifo_empty[g] is high with no read issued this cycle.
  - On release: ptr <= (g+1) mod N, grant <= 0, go to IDLE.
  - Release happens on the edge after the last read. The next grant is chosen in the following IDLE cycle.
- A stall caused by the credit rule (out_ready low) does not release the grant and does not advance the count.
- Capture: the cycle after fifo_rd_en[g], {fifo_dout[g], g} is pushed into the buffer. A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Ordering: words from one FIFO leave in FIFO order. No word is duplicated or dropped while reset is inactive.
- Wrap-around: ptr and the scan wrap modulo N. With N=4, after a release from FIFO 3 the scan starts at 0.
- Reset mid-operation: all state clears on the next edge and in-flight read data is discarded. fifo_rd_en is 0 in the reset cycle.
- Fairness: with every FIFO non-empty and out_ready=1, the grant order is 0,1,…,N−1,0,… with exactly BURST words each.

Test Plan:
1. Reset low 3 cycles with all FIFOs holding data -> fifo_rd_en=0, out_valid=0, grant=0 throughout; first grant to FIFO 0 on the first cycle after reset releases.
2. Only FIFO 2 non-empty with 10 words, out_ready=1, BURST=4 -> reads in bursts 4,4,2 from FIFO 2 with a 1-cycle IDLE gap between them; out_src=2 for all 10 words; words leave in order; no read while fifo_empty[2]=1.
3. All 4 FIFOs hold 8 words, out_ready=1 -> out_src sequence is 0×4,1×4,2×4,3×4,0×4,…; 32 words total; throughput is 4 words per 5 cycles.
4. FIFO 1 holds 6 words, out_ready held 0 after the first 2 words are buffered -> fifo_rd_en stops, occupancy=2, out_data stable; after out_ready=1, the remaining words arrive with no loss or duplication.
5. FIFO 3 holds 1 word and FIFO 0 holds 1 word, ptr=3 -> FIFO 3 is served first, then ptr wraps and FIFO 0 is served; out_src sequence is 3,0.
6. reset pulled low the cycle after fifo_rd_en[1] asserts -> that word never appears on the output; all outputs return to reset values on the next edge.
